// File: rtl/led_seq_ctrl_pkg.sv
// Shared definitions for the LED sequencer family: mode encoding,
// bounce direction and default step timing (100 ms at 50 MHz).
package led_seq_ctrl_pkg;

  // Mode encoding seen on Mode_Sel; also used directly as the FSM state.
  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  // Direction of travel for the bounce pattern.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int unsigned DEF_T_STEP = 5_000_000;
  localparam int unsigned DEF_CNT_W  = 23;

endpackage

// File: rtl/led_step_prescaler.sv
// Free-running step prescaler: counts 0..T_STEP-1 and wraps, flagging
// the last count of each step. Reusable by any LED pattern block.
module led_step_prescaler
  import led_seq_ctrl_pkg::*;
#(
  parameter int unsigned T_STEP = DEF_T_STEP,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST_n,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tick
);

  // Terminal count held at counter width so the compare never truncates.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(T_STEP - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_tick;

  assign w_tick  = (r_count == LAST);
  assign o_tick  = w_tick;
  assign o_count = r_count;

  // Step counter: wraps to zero on the terminal count.
  always_ff @(posedge CLK or negedge RST_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    if (!RST_n) begin
      r_count <= '0;
    end else if (w_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: OFF / CHASE / BLINK / BOUNCE on N_LED outputs.
// Mode requests are buffered and applied only on step boundaries so a
// pattern never changes mid-step; LED_Out is registered.
module led_seq_ctrl
  import led_seq_ctrl_pkg::*;
#(
  parameter int unsigned T_STEP = DEF_T_STEP,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned N_LED  = 4
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic [1:0]       Mode_Sel,
  input  logic             Mode_Req,
  output logic             Mode_Ack,
  output logic             Step_Tick,
  output logic [N_LED-1:0] LED_Out,
  output logic             Busy
);

  localparam int unsigned      POS_W    = $clog2(N_LED);
  localparam logic [POS_W-1:0] POS_MAX  = POS_W'(N_LED - 1);
  // Blink is lit for the first quarter of each step.
  localparam logic [CNT_W-1:0] BLINK_ON = CNT_W'(T_STEP / 4);

  logic [CNT_W-1:0] w_count;
  logic             w_tick;
  logic             w_apply;

  mode_e            r_state, w_state_nxt;
  logic [POS_W-1:0] r_pos, w_pos_nxt;
  dir_e             r_dir, w_dir_nxt;
  logic [N_LED-1:0] w_led_nxt;

  logic             r_pend_valid;
  mode_e            r_pend_mode;

  logic [N_LED-1:0] r_led;
  logic             r_ack;
  logic             r_step_tick;

  led_step_prescaler #(
    .T_STEP (T_STEP),
    .CNT_W  (CNT_W)
  ) u_prescaler (
    .CLK     (CLK),
    .RST_n   (RST_n),
    .o_count (w_count),
    .o_tick  (w_tick)
  );

  // Only a request already pending before this tick is applied; one
  // arriving on the tick itself waits for the next boundary.
  assign w_apply = w_tick & r_pend_valid;

  // Next-state, pattern position and LED pattern for the coming cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_dir_nxt   = r_dir;
    w_led_nxt   = '0;

    if (w_apply) begin
      // Apply wins over advance: the new pattern always starts at pos 0.
      w_state_nxt = r_pend_mode;
      w_pos_nxt   = '0;
      w_dir_nxt   = DIR_UP;
    end else if (w_tick) begin
      case (r_state)
        MODE_CHASE: w_pos_nxt = r_pos + 1'b1;  // power-of-two N_LED wraps
        MODE_BOUNCE: begin
          if (r_dir == DIR_UP) begin
            if (r_pos == POS_MAX) begin
              w_pos_nxt = r_pos - 1'b1;
              w_dir_nxt = DIR_DOWN;
            end else begin
              w_pos_nxt = r_pos + 1'b1;
            end
          end else begin
            if (r_pos == '0) begin
              w_pos_nxt = r_pos + 1'b1;
              w_dir_nxt = DIR_UP;
            end else begin
              w_pos_nxt = r_pos - 1'b1;
            end
          end
        end
        default: ;  // OFF and BLINK hold pos
      endcase
    end

    case (r_state)
      MODE_CHASE, MODE_BOUNCE: w_led_nxt = N_LED'(1) << r_pos;
      MODE_BLINK:              w_led_nxt = (w_count < BLINK_ON) ? '1 : '0;
      default:                 w_led_nxt = '0;
    endcase
  end

  // FSM state register with pattern position and bounce direction.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state <= MODE_OFF;
      r_pos   <= '0;
      r_dir   <= DIR_UP;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  // Request capture: last request wins; a new request outranks clearing.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_pend_valid <= 1'b0;
      r_pend_mode  <= MODE_OFF;
    end else if (Mode_Req) begin
      r_pend_valid <= 1'b1;
      r_pend_mode  <= mode_e'(Mode_Sel);
    end else if (w_apply) begin
      r_pend_valid <= 1'b0;
    end
  end

  // Registered outputs: LED drive, apply acknowledge and step tick.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_led       <= '0;
      r_ack       <= 1'b0;
      r_step_tick <= 1'b0;
    end else begin
      r_led       <= w_led_nxt;
      r_ack       <= w_apply;
      r_step_tick <= w_tick;
    end
  end

  assign LED_Out   = r_led;
  assign Mode_Ack  = r_ack;
  assign Step_Tick = r_step_tick;
  assign Busy      = r_pend_valid;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl with T_STEP=8, N_LED=4.
// The reference model tracks the step count since the last apply and
// derives each pattern arithmetically (one-hot of k mod N, triangle wave).
module tb_led_seq_ctrl;

  localparam int T  = 8;
  localparam int CW = 4;
  localparam int N  = 4;

  logic         CLK      = 1'b0;
  logic         RST_n    = 1'b0;
  logic         Mode_Req = 1'b0;
  logic [1:0]   Mode_Sel = 2'd0;
  logic         Mode_Ack;
  logic         Step_Tick;
  logic         Busy;
  logic [N-1:0] LED_Out;

  int n_checks = 0;
  int n_pass   = 0;
  int ack_seen = 0;
  int tick_seen = 0;

  // Reference model state
  int           m_cnt, m_mode, m_k, m_pm;
  bit           m_pv;
  logic [N-1:0] e_led;
  bit           e_ack, e_tick;

  led_seq_ctrl #(
    .T_STEP (T),
    .CNT_W  (CW),
    .N_LED  (N)
  ) dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .Mode_Sel  (Mode_Sel),
    .Mode_Req  (Mode_Req),
    .Mode_Ack  (Mode_Ack),
    .Step_Tick (Step_Tick),
    .LED_Out   (LED_Out),
    .Busy      (Busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [N-1:0] pattern(input int mode, input int k, input int cnt);
    int p;
    int pos;
    logic [N-1:0] one;
    one = 1;
    p   = k % (2 * N - 2);
    pos = (p < N) ? p : (2 * N - 2 - p);
    case (mode)
      1:       return one << (k % N);
      2:       return (cnt < T / 4) ? {N{1'b1}} : {N{1'b0}};
      3:       return one << pos;
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_mode = 0;
    m_k    = 0;
    m_pv   = 0;
    m_pm   = 0;
  endtask

  // One clock edge of the reference model, using pre-edge values.
  task automatic model_edge(input bit req, input int sel);
    bit tick, apply;
    tick   = (m_cnt == T - 1);
    apply  = tick && m_pv;
    e_tick = tick;
    e_ack  = apply;
    e_led  = pattern(m_mode, m_k, m_cnt);
    if (apply) begin
      m_mode = m_pm;
      m_k    = 0;
    end else if (tick) begin
      m_k++;
    end
    if (req) begin
      m_pv = 1;
      m_pm = sel;
    end else if (apply) begin
      m_pv = 0;
    end
    m_cnt = (m_cnt + 1) % T;
  endtask

  task automatic cycle(input bit req, input int sel);
    Mode_Req = req;
    Mode_Sel = sel[1:0];
    @(posedge CLK);
    model_edge(req, sel);
    #1;
    Mode_Req = 1'b0;
    check("led", LED_Out, e_led);
    check("ack", Mode_Ack, e_ack);
    check("step_tick", Step_Tick, e_tick);
    check("busy", Busy, m_pv);
    if (Mode_Ack) ack_seen++;
    if (Step_Tick) tick_seen++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 0);
  endtask

  // Advance until the next edge will sample the counter at value t.
  task automatic wait_cnt(input int t);
    for (int i = 0; i < T && m_cnt != t; i++) cycle(1'b0, 0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic do_reset();
    #3;
    RST_n = 1'b0;
    #1;
    model_reset();
    check("rst_led", LED_Out, 0);
    check("rst_ack", Mode_Ack, 0);
    check("rst_tick", Step_Tick, 0);
    check("rst_busy", Busy, 0);
    @(posedge CLK);
    #1;
    check("rst_hold_led", LED_Out, 0);
    RST_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #3;
    check("init_led", LED_Out, 0);
    check("init_busy", Busy, 0);
    check("init_ack", Mode_Ack, 0);
    check("init_tick", Step_Tick, 0);
    @(posedge CLK);
    #1;
    RST_n = 1'b1;

    // OFF after reset: dark, ticks every 8 cycles, no ack
    ack_seen = 0;
    tick_seen = 0;
    idle(16);
    check("off_ticks", tick_seen, 2);
    check("off_acks", ack_seen, 0);

    // CHASE requested at counter=2
    wait_cnt(2);
    ack_seen = 0;
    cycle(1'b1, 1);
    check("chase_busy", Busy, 1);
    idle(5 * T);
    check("chase_acks", ack_seen, 1);

    // BLINK
    wait_cnt(5);
    ack_seen = 0;
    cycle(1'b1, 2);
    idle(4 * T);
    check("blink_acks", ack_seen, 1);

    // BOUNCE over more than one full triangle period
    ack_seen = 0;
    cycle(1'b1, 3);
    idle(9 * T);
    check("bounce_acks", ack_seen, 1);

    // Request landing exactly on a tick waits a full step
    wait_cnt(T - 1);
    ack_seen = 0;
    cycle(1'b1, 2);
    idle(T - 1);
    check("tick_req_not_yet", ack_seen, 0);
    idle(1);
    check("tick_req_applied", ack_seen, 1);

    // Two requests before one boundary: single ack, last one wins
    wait_cnt(1);
    ack_seen = 0;
    cycle(1'b1, 1);
    idle(2);
    cycle(1'b1, 3);
    idle(2 * T);
    check("overwrite_acks", ack_seen, 1);

    // Re-applying the current mode restarts the pattern and acks again
    ack_seen = 0;
    cycle(1'b1, 3);
    idle(2 * T);
    check("same_mode_acks", ack_seen, 1);

    // Reset during CHASE with a request pending
    cycle(1'b1, 1);
    idle(2 * T);
    cycle(1'b1, 2);
    idle(2);
    do_reset();
    ack_seen = 0;
    idle(4 * T);
    check("no_stale_apply", ack_seen, 0);

    // Random traffic with rare resets
    repeat (1500) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else cycle($urandom_range(0, 9) == 0, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
